// File: rtl/wmc_panel.sv
// Front-panel conditioner for the washing-machine controller: synchronises and
// debounces start/stop/door, drives the door lock and issues start/stop pulses.
module wmc_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCK_CYCLES     = 3,
    parameter int unsigned UNLOCK_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_closed,
    input  logic       cycle_done,
    output logic       start,
    output logic       stop,
    output logic       door_lock,
    output logic       fault,
    output logic [1:0] panel_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK   = 2'd1,
        RUN    = 2'd2,
        UNLOCK = 2'd3
    } state_e;

    localparam logic [7:0] DEB_N    = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_CYCLES);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CYCLES);

    // Bit 0 = start button, bit 1 = stop button, bit 2 = door switch.
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      lvl_q, lvl_d;
    logic [2:0][7:0] db_cnt_q, db_cnt_d;
    logic [1:0]      prev_q;

    assign raw = {door_closed, stop_btn, start_btn};

    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] + 8'd1 == DEB_N) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            db_cnt_q <= '0;
            prev_q   <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            db_cnt_q <= db_cnt_d;
            prev_q   <= lvl_q[1:0];
        end
    end

    logic start_press, stop_press, door_ok;

    assign start_press = lvl_q[0] & ~prev_q[0];
    assign stop_press  = lvl_q[1] & ~prev_q[1];
    assign door_ok     = lvl_q[2];

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       start_q, stop_q, lock_q, fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            lock_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_press && !stop_press) begin
                        if (door_ok) begin
                            state_q <= LOCK;
                            cnt_q   <= '0;
                            lock_q  <= 1'b1;
                            fault_q <= 1'b0;
                        end else begin
                            fault_q <= 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (!door_ok) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        lock_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else if (stop_press) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        lock_q  <= 1'b0;
                    end else if (cnt_q + 8'd1 == LOCK_N) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    // A stop request or open door wins over cycle_done so stop is still pulsed.
                    if (stop_press || !door_ok) begin
                        state_q <= UNLOCK;
                        cnt_q   <= '0;
                        stop_q  <= 1'b1;
                        if (!door_ok) begin
                            fault_q <= 1'b1;
                        end
                    end else if (cycle_done) begin
                        state_q <= UNLOCK;
                        cnt_q   <= '0;
                    end
                end
                UNLOCK: begin
                    if (cnt_q + 8'd1 == UNLOCK_N) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        lock_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign start       = start_q;
    assign stop        = stop_q;
    assign door_lock   = lock_q;
    assign fault       = fault_q;
    assign panel_state = state_q;

endmodule

// File: tb/tb_wmc_panel.sv
// Bench for wmc_panel: directed scenarios plus randomized button/door activity,
// all checked against a window-based debounce and entry-time FSM model.
module tb_wmc_panel;

    localparam int DEB = 4;
    localparam int LCK = 3;
    localparam int UNL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       door_closed = 1'b0;
    logic       cycle_done = 1'b0;
    logic       start, stop, door_lock, fault;
    logic [1:0] panel_state;
    logic [5:0] dut_v;

    wmc_panel #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCK_CYCLES(LCK),
        .UNLOCK_CYCLES(UNL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_btn(start_btn),
        .stop_btn(stop_btn),
        .door_closed(door_closed),
        .cycle_done(cycle_done),
        .start(start),
        .stop(stop),
        .door_lock(door_lock),
        .fault(fault),
        .panel_state(panel_state)
    );

    always #5 clk = ~clk;

    assign dut_v = {start, stop, door_lock, fault, panel_state};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: raw history per edge, debounced level flips once the last
    // DEB synchronised samples all disagree with it; FSM timers use entry edges.
    logic [2:0] raw_hist[$];
    logic [2:0] m_lvl, m_prev;
    int         m_state, m_entry, edge_n;
    logic       m_start, m_stop, m_lock, m_fault;

    function automatic void model_reset();
        raw_hist.delete();
        for (int i = 0; i < DEB + 2; i++) raw_hist.push_back(3'b000);
        m_lvl   = '0;
        m_prev  = '0;
        m_state = 0;
        m_entry = 0;
        m_start = 1'b0;
        m_stop  = 1'b0;
        m_lock  = 1'b0;
        m_fault = 1'b0;
    endfunction

    function automatic void model_edge(input logic [2:0] r, input logic cd);
        logic       sp, tp, door, all_diff;
        logic [2:0] nl;
        int         sz;
        sp   = m_lvl[0] & ~m_prev[0];
        tp   = m_lvl[1] & ~m_prev[1];
        door = m_lvl[2];
        nl   = m_lvl;
        edge_n++;
        m_start = 1'b0;
        m_stop  = 1'b0;
        case (m_state)
            0: if (sp && !tp) begin
                if (door) begin
                    m_state = 1; m_entry = edge_n; m_lock = 1'b1; m_fault = 1'b0;
                end else begin
                    m_fault = 1'b1;
                end
            end
            1: if (!door) begin
                m_state = 0; m_lock = 1'b0; m_fault = 1'b1;
            end else if (tp) begin
                m_state = 0; m_lock = 1'b0;
            end else if (edge_n - m_entry == LCK) begin
                m_state = 2; m_entry = edge_n; m_start = 1'b1;
            end
            2: if (tp || !door) begin
                m_state = 3; m_entry = edge_n; m_stop = 1'b1;
                if (!door) m_fault = 1'b1;
            end else if (cd) begin
                m_state = 3; m_entry = edge_n;
            end
            default: if (edge_n - m_entry == UNL) begin
                m_state = 0; m_lock = 1'b0;
            end
        endcase
        raw_hist.push_back(r);
        sz = raw_hist.size();
        for (int i = 0; i < 3; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (raw_hist[sz - 3 - j][i] == m_lvl[i]) all_diff = 1'b0;
            if (all_diff) nl[i] = ~m_lvl[i];
        end
        m_prev = m_lvl;
        m_lvl  = nl;
        if (raw_hist.size() > 32) void'(raw_hist.pop_front());
    endfunction

    function automatic logic [5:0] exp_v();
        logic [1:0] s;
        s = m_state[1:0];
        return {m_start, m_stop, m_lock, m_fault, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge({door_closed, stop_btn, start_btn}, cycle_done);
        #1;
    endtask

    task automatic settle_door(input logic v);
        door_closed = v;
        repeat (DEB + 4) tick();
    endtask

    task automatic to_idle();
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle_done = (m_state == 2);
            tick();
        end
        cycle_done = 1'b0;
    endtask

    task automatic to_run();
        start_btn = 1'b1;
        repeat (12) tick();
        start_btn = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (dut_v !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected %b", dut_v, 6'b000000);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL post_reset: got %b expected %b", dut_v, exp_v());
            end
        end
    endtask

    task automatic test_normal();
        int lock_at, run_at;
        lock_at = -1;
        run_at  = -1;
        settle_door(1'b1);
        start_btn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 9) start_btn = 1'b0;
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL normal_cycle: edge %0d got %b expected %b", i, dut_v, exp_v());
            end
            if (panel_state == 2'd1 && door_lock && lock_at < 0) lock_at = i;
            if (start && run_at < 0) run_at = i;
        end
        n_vec++;
        if (lock_at !== 6) begin
            n_bad++;
            $display("FAIL lock_entry_edge: got %0d expected %0d", lock_at, 6);
        end
        n_vec++;
        if (run_at !== 9) begin
            n_bad++;
            $display("FAIL start_pulse_edge: got %0d expected %0d", run_at, 9);
        end
        cycle_done = 1'b1;
        tick();
        cycle_done = 1'b0;
        n_vec++;
        if (panel_state !== 2'd3 || stop !== 1'b0 || door_lock !== 1'b1) begin
            n_bad++;
            $display("FAIL done_to_unlock: got state %0d stop %b lock %b expected 3 0 1",
                     panel_state, stop, door_lock);
        end
        for (int i = 1; i <= UNL; i++) begin
            tick();
            n_vec++;
            if (door_lock !== (i < UNL)) begin
                n_bad++;
                $display("FAIL unlock_hold: step %0d got lock %b expected %b", i, door_lock, i < UNL);
            end
        end
        n_vec++;
        if (panel_state !== 2'd0) begin
            n_bad++;
            $display("FAIL unlock_to_idle: got %0d expected 0", panel_state);
        end
        to_idle();
    endtask

    task automatic test_bounce();
        int entries, first_at;
        logic [1:0] last;
        entries  = 0;
        first_at = -1;
        last     = panel_state;
        for (int i = 0; i < 34; i++) begin
            start_btn = (i >= 20) ? 1'b1 : ~((i >> 1) & 1);
            tick();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL bounce: edge %0d got %b expected %b", i, dut_v, exp_v());
            end
            if (panel_state == 2'd1 && last == 2'd0) begin
                entries++;
                if (first_at < 0) first_at = i;
            end
            last = panel_state;
        end
        n_vec++;
        if (entries !== 1 || first_at < 20) begin
            n_bad++;
            $display("FAIL bounce_entries: got %0d entries first at %0d expected 1 at >=20", entries, first_at);
        end
        to_idle();
    endtask

    task automatic test_door_open();
        settle_door(1'b0);
        start_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL door_open_start: got %b expected %b", dut_v, exp_v());
            end
        end
        n_vec++;
        if (panel_state !== 2'd0 || fault !== 1'b1 || door_lock !== 1'b0) begin
            n_bad++;
            $display("FAIL door_open_fault: got state %0d fault %b lock %b expected 0 1 0",
                     panel_state, fault, door_lock);
        end
        start_btn = 1'b0;
        repeat (8) tick();
        settle_door(1'b1);
        start_btn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (panel_state == 2'd1) begin
                n_vec++;
                if (fault !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fault_clear: got %b expected 0", fault);
                end
            end
        end
        to_idle();
    endtask

    task automatic test_abort();
        int stops, unlock_at, idle_at;
        stops     = 0;
        unlock_at = -1;
        idle_at   = -1;
        to_run();
        stop_btn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) start_btn = 1'b1;
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL abort: edge %0d got %b expected %b", i, dut_v, exp_v());
            end
            if (stop) stops++;
            if (panel_state == 2'd3 && unlock_at < 0) unlock_at = i;
            if (unlock_at >= 0 && panel_state == 2'd0 && idle_at < 0) idle_at = i;
        end
        n_vec++;
        if (stops !== 1 || unlock_at !== 6 || idle_at !== 9) begin
            n_bad++;
            $display("FAIL abort_timing: got stops %0d unlock %0d idle %0d expected 1 6 9",
                     stops, unlock_at, idle_at);
        end
        n_vec++;
        if (panel_state !== 2'd0 || door_lock !== 1'b0) begin
            n_bad++;
            $display("FAIL unlock_ignores_start: got state %0d lock %b expected 0 0", panel_state, door_lock);
        end
        to_idle();
    endtask

    task automatic test_simultaneous();
        int starts;
        to_run();
        stop_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle_done = (i == 6);
            tick();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL stop_vs_done: edge %0d got %b expected %b", i, dut_v, exp_v());
            end
            if (i == 6) begin
                n_vec++;
                if (stop !== 1'b1 || panel_state !== 2'd3) begin
                    n_bad++;
                    $display("FAIL stop_beats_done: got stop %b state %0d expected 1 3", stop, panel_state);
                end
            end
        end
        cycle_done = 1'b0;
        to_idle();

        start_btn = 1'b1;
        stop_btn  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (panel_state !== 2'd0 || dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL start_stop_idle: got %b expected %b", dut_v, exp_v());
            end
        end
        to_idle();

        starts    = 0;
        start_btn = 1'b1;
        tick();
        door_closed = 1'b0;
        for (int i = 1; i < 14; i++) begin
            tick();
            if (start) starts++;
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL door_in_lock: edge %0d got %b expected %b", i, dut_v, exp_v());
            end
        end
        n_vec++;
        if (starts !== 0 || panel_state !== 2'd0 || fault !== 1'b1 || door_lock !== 1'b0) begin
            n_bad++;
            $display("FAIL door_open_lock_abort: got starts %0d state %0d fault %b lock %b expected 0 0 1 0",
                     starts, panel_state, fault, door_lock);
        end
        start_btn = 1'b0;
        settle_door(1'b1);
        to_idle();
    endtask

    task automatic test_reset_mid_run();
        to_run();
        n_vec++;
        if (panel_state !== 2'd2 || door_lock !== 1'b1) begin
            n_bad++;
            $display("FAIL reach_run: got state %0d lock %b expected 2 1", panel_state, door_lock);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if (dut_v !== 6'b000000) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected %b", dut_v, 6'b000000);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL after_async_reset: got %b expected %b", dut_v, exp_v());
            end
        end
    endtask

    task automatic test_random();
        int hold_s, hold_t, hold_d;
        hold_s = 0;
        hold_t = 0;
        hold_d = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_s == 0) begin
                start_btn = 1'($urandom_range(0, 1));
                hold_s    = $urandom_range(1, 12);
            end
            if (hold_t == 0) begin
                stop_btn = ($urandom_range(0, 3) == 0);
                hold_t   = $urandom_range(1, 12);
            end
            if (hold_d == 0) begin
                door_closed = ($urandom_range(0, 5) != 0);
                hold_d      = $urandom_range(2, 40);
            end
            hold_s--;
            hold_t--;
            hold_d--;
            cycle_done = ($urandom_range(0, 15) == 0);
            tick();
            n_vec++;
            if (dut_v !== exp_v()) begin
                n_bad++;
                $display("FAIL random: step %0d got %b expected %b", i, dut_v, exp_v());
            end
        end
        cycle_done = 1'b0;
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        test_reset();
        test_normal();
        test_bounce();
        test_door_open();
        test_abort();
        test_simultaneous();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
